// File: rtl/dw_asymfifo_rd_unpack.sv
// Read-side width down-converter: pops wide words from a fall-through FIFO and
// presents each one to a narrow consumer as K sub-words, zero latency.
module dw_asymfifo_rd_unpack #(
  parameter int in_width   = 32,
  parameter int out_width  = 8,
  parameter int byte_order = 0,
  parameter int err_mode   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [in_width-1:0]  fifo_rd_data,
  output logic                 fifo_pop_n,
  input  logic                 pop_req_n,
  input  logic                 flush_n,
  output logic [out_width-1:0] data_out,
  output logic                 empty,
  output logic                 part_rd,
  output logic                 error
);

  localparam int k     = in_width / out_width;
  localparam int idx_w = (k > 1) ? $clog2(k) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(k - 1);

  typedef enum logic {IDLE = 1'b0, HOLDING = 1'b1} state_t;

  state_t                state;
  logic [in_width-1:0]   hold_q;
  logic [idx_w-1:0]      idx;
  logic                  err_q;

  logic                  hold_v;
  logic                  accept;
  logic                  underflow;
  logic [in_width-1:0]   src;
  logic [out_width-1:0]  sub_words [k];

  assign hold_v    = (state == HOLDING);
  assign src       = hold_v ? hold_q : fifo_rd_data;
  assign empty     = !hold_v && fifo_empty;
  assign part_rd   = hold_v;
  assign accept    = !pop_req_n && flush_n && !empty;
  assign underflow = !pop_req_n && flush_n && empty;
  // Upstream is popped only on the first sub-word, when the word is captured.
  assign fifo_pop_n = !(accept && !hold_v);
  assign error      = err_q;

  genvar gi;
  generate
    for (gi = 0; gi < k; gi++) begin : g_sub
      if (byte_order == 0) begin : g_msb_first
        assign sub_words[gi] = src[in_width-1-gi*out_width -: out_width];
      end else begin : g_lsb_first
        assign sub_words[gi] = src[gi*out_width +: out_width];
      end
    end
  endgenerate

  // idx is always 0 when idle, so the fall-through head shows its first sub-word.
  assign data_out = sub_words[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold_q <= '0;
      idx    <= '0;
    end else if (!flush_n) begin
      state <= IDLE;
      idx   <= '0;
    end else if (accept) begin
      if (!hold_v) begin
        state  <= HOLDING;
        hold_q <= fifo_rd_data;
        idx    <= idx_w'(1);
      end else if (idx == last_idx) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + idx_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_mode == 0) begin
      if (underflow) err_q <= 1'b1;
    end else begin
      err_q <= underflow;
    end
  end

endmodule

// File: tb/tb_dw_asymfifo_rd_unpack.sv
// Bench for dw_asymfifo_rd_unpack: two instances (MS-first/sticky error and
// LS-first/per-cycle error) share stimulus and are checked against a queue model.
module tb_dw_asymfifo_rd_unpack;
  localparam int IW = 32;
  localparam int OW = 8;
  localparam int K  = IW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [IW-1:0] fifo_rd_data = '0;
  logic          pop_req_n = 1'b1;
  logic          flush_n = 1'b1;
  logic          pop_n0, pop_n1, empty0, empty1, part0, part1, err0, err1;
  logic [OW-1:0] dout0, dout1;

  int total = 0;
  int bad = 0;

  // Upstream FIFO contents and, per byte order, the sub-words still owed from
  // the word currently being unpacked.
  logic [IW-1:0] up_q[$];
  logic [OW-1:0] rem0[$];
  logic [OW-1:0] rem1[$];
  bit m_err0 = 1'b0;
  bit m_err1 = 1'b0;

  always #5 clk = ~clk;

  dw_asymfifo_rd_unpack #(.in_width(IW), .out_width(OW), .byte_order(0), .err_mode(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_pop_n(pop_n0), .pop_req_n(pop_req_n), .flush_n(flush_n), .data_out(dout0),
    .empty(empty0), .part_rd(part0), .error(err0));

  dw_asymfifo_rd_unpack #(.in_width(IW), .out_width(OW), .byte_order(1), .err_mode(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_pop_n(pop_n1), .pop_req_n(pop_req_n), .flush_n(flush_n), .data_out(dout1),
    .empty(empty1), .part_rd(part1), .error(err1));

  function automatic logic [OW-1:0] sub_of(logic [IW-1:0] w, int i, bit lsb_first);
    int pos;
    pos = lsb_first ? i : (K - 1 - i);
    return w[pos*OW +: OW];
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input bit pop, input bit flush, input string tag);
    bit exp_empty, exp_part, exp_popn, acc, uf;
    logic [OW-1:0] e0, e1;
    logic [IW-1:0] w;
    @(negedge clk);
    pop_req_n    = !pop;
    flush_n      = !flush;
    fifo_empty   = (up_q.size() == 0);
    fifo_rd_data = fifo_empty ? IW'($urandom) : up_q[0];
    #1;
    exp_empty = (rem0.size() == 0) && fifo_empty;
    exp_part  = (rem0.size() != 0);
    acc       = pop && !flush && !exp_empty;
    uf        = pop && !flush && exp_empty;
    exp_popn  = !(acc && rem0.size() == 0);
    e0 = '0;
    e1 = '0;
    if (!exp_empty) begin
      e0 = (rem0.size() != 0) ? rem0[0] : sub_of(up_q[0], 0, 1'b0);
      e1 = (rem1.size() != 0) ? rem1[0] : sub_of(up_q[0], 0, 1'b1);
      total++;
      if (dout0 !== e0) begin bad++; $display("FAIL %s data_out0 got=%h exp=%h", tag, dout0, e0); end
      total++;
      if (dout1 !== e1) begin bad++; $display("FAIL %s data_out1 got=%h exp=%h", tag, dout1, e1); end
    end
    total++;
    if (empty0 !== exp_empty || empty1 !== exp_empty) begin
      bad++; $display("FAIL %s empty got=%b/%b exp=%b", tag, empty0, empty1, exp_empty);
    end
    total++;
    if (part0 !== exp_part || part1 !== exp_part) begin
      bad++; $display("FAIL %s part_rd got=%b/%b exp=%b", tag, part0, part1, exp_part);
    end
    total++;
    if (pop_n0 !== exp_popn || pop_n1 !== exp_popn) begin
      bad++; $display("FAIL %s fifo_pop_n got=%b/%b exp=%b", tag, pop_n0, pop_n1, exp_popn);
    end
    total++;
    if (err0 !== m_err0) begin bad++; $display("FAIL %s error0 got=%b exp=%b", tag, err0, m_err0); end
    total++;
    if (err1 !== m_err1) begin bad++; $display("FAIL %s error1 got=%b exp=%b", tag, err1, m_err1); end
    $display("%s pop=%0b flush=%0b empty=%0b data=%h/%h pop_n=%0b part=%0b err=%0b/%0b",
             tag, pop, flush, empty0, dout0, dout1, pop_n0, part0, err0, err1);
    if (flush) begin
      rem0.delete();
      rem1.delete();
    end else if (acc) begin
      if (rem0.size() == 0) begin
        w = up_q.pop_front();
        for (int i = 0; i < K; i++) begin
          rem0.push_back(sub_of(w, i, 1'b0));
          rem1.push_back(sub_of(w, i, 1'b1));
        end
      end
      void'(rem0.pop_front());
      void'(rem1.pop_front());
    end
    m_err0 = m_err0 | uf;
    m_err1 = uf;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rem0.size() != 0 || up_q.size() != 0); i++) cycle(1'b1, 1'b0, "drain");
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (empty0 !== 1'b1 || part0 !== 1'b0 || err0 !== 1'b0 || pop_n0 !== 1'b1) begin
      bad++; $display("FAIL reset_idle got empty=%b part=%b err=%b pop_n=%b exp 1 0 0 1", empty0, part0, err0, pop_n0);
    end
    up_q.push_back(32'hA1B2C3D4);
    fifo_empty   = 1'b0;
    fifo_rd_data = 32'hA1B2C3D4;
    #1;
    total++;
    if (empty0 !== 1'b0 || dout0 !== 8'hA1 || dout1 !== 8'hD4) begin
      bad++; $display("FAIL reset_head got empty=%b data=%h/%h exp 0 a1/d4", empty0, dout0, dout1);
    end
    $display("reset empty=%0b data=%h/%h", empty0, dout0, dout1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unpack();
    logic [OW-1:0] tab0 [K];
    logic [OW-1:0] tab1 [K];
    tab0 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tab1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < K; i++) begin
      cycle(1'b1, 1'b0, "unpack");
      total++;
      if (dout0 !== tab0[i] || dout1 !== tab1[i] || pop_n0 !== (i != 0) || part0 !== (i != 0)) begin
        bad++; $display("FAIL unpack_%0d got data=%h/%h pop_n=%b part=%b exp %h/%h %b %b",
                        i, dout0, dout1, pop_n0, part0, tab0[i], tab1[i], i != 0, i != 0);
      end
    end
    cycle(1'b0, 1'b0, "unpack_idle");
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] tab [2*K];
    tab = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    up_q.push_back(32'h11223344);
    up_q.push_back(32'h55667788);
    for (int i = 0; i < 2*K; i++) begin
      cycle(1'b1, 1'b0, "b2b");
      total++;
      if (dout0 !== tab[i] || pop_n0 !== !(i == 0 || i == K)) begin
        bad++; $display("FAIL b2b_%0d got data=%h pop_n=%b exp %h %b", i, dout0, pop_n0, tab[i], !(i == 0 || i == K));
      end
    end
    cycle(1'b0, 1'b0, "b2b_after");
    total++;
    if (empty0 !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty0); end
  endtask

  task automatic test_flush();
    up_q.push_back(32'hA1B2C3D4);
    up_q.push_back(32'h55667788);
    cycle(1'b1, 1'b0, "flush_pre");
    cycle(1'b1, 1'b0, "flush_pre");
    cycle(1'b1, 1'b1, "flush");
    total++;
    if (pop_n0 !== 1'b1) begin bad++; $display("FAIL flush_nopop got=%b exp=1", pop_n0); end
    cycle(1'b0, 1'b0, "flush_post");
    total++;
    if (part0 !== 1'b0) begin bad++; $display("FAIL flush_part got=%b exp=0", part0); end
    cycle(1'b1, 1'b0, "flush_next");
    total++;
    if (dout0 !== 8'h55 || pop_n0 !== 1'b0) begin
      bad++; $display("FAIL flush_next got data=%h pop_n=%b exp 55 0", dout0, pop_n0);
    end
    cycle(1'b0, 1'b1, "flush_idle");
    drain();
  endtask

  task automatic test_error();
    drain();
    cycle(1'b1, 1'b0, "underflow");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, "err_hold");
      total++;
      if (err0 !== 1'b1 || err1 !== (i == 0)) begin
        bad++; $display("FAIL err_hold_%0d got=%b/%b exp=1/%b", i, err0, err1, i == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    up_q.push_back(32'hDEADBEEF);
    up_q.push_back(32'h0BADCAFE);
    cycle(1'b1, 1'b0, "rmid_pop");
    @(negedge clk);
    pop_req_n = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if (part0 !== 1'b0 || err0 !== 1'b0 || pop_n0 !== 1'b1) begin
      bad++; $display("FAIL reset_mid got part=%b err=%b pop_n=%b exp 0 0 1", part0, err0, pop_n0);
    end
    $display("reset_mid part=%0b err=%0b", part0, err0);
    rem0.delete();
    rem1.delete();
    m_err0 = 1'b0;
    m_err1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, "rmid_next");
    total++;
    if (pop_n0 !== 1'b0 || dout0 !== 8'h0B) begin
      bad++; $display("FAIL reset_mid_next got pop_n=%b data=%h exp 0 0b", pop_n0, dout0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (up_q.size() < 4 && $urandom_range(0, 2) == 0) up_q.push_back(IW'($urandom));
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_unpack();
    test_back_to_back();
    test_flush();
    test_error();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
